// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter width.
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;
  localparam int WIDTH_DEF = 8;
  localparam int CNT_W     = $clog2(WIDTH_DEF);
endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle of the bit-serial adder; master drives operands, slave returns results.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (output start, a, b, cin, sub,
                  input  busy, done, sum, cout, overflow);
  modport slave  (input  start, a, b, cin, sub,
                  output busy, done, sum, cout, overflow);
endinterface

// File: rtl/fa_bit_cell.sv
// Combinational single-bit full adder used as the serial datapath.
module fa_bit_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: LSB-first through one full-adder cell, carry kept in a FF.
// Define SERIAL_SUB_EN to enable a-b via the sub input.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, c_msb_q, c_msb_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             fa_s, fa_co;

`ifndef SERIAL_SUB_EN
  logic unused_sub;
  assign unused_sub = bus.sub;
`endif

  fa_bit_cell u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          carry_d  = bus.cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          c_msb_d  = 1'b0;
`ifdef SERIAL_SUB_EN
          // two's-complement subtract: a + ~b + 1
          if (bus.sub) begin
            b_sh_d  = ~bus.b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      SHIFT: begin
        sum_sh_d = {fa_s, sum_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_co;
        cnt_d    = cnt_q + 1'b1;
        // carry produced by bit WIDTH-2 is the carry into the MSB
        if (cnt_q == PENULT) c_msb_d = fa_co;
        if (cnt_q == LAST) begin
          state_d = DONE;
          sum_d   = {fa_s, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = c_msb_q ^ fa_co;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8); expectations follow SERIAL_SUB_EN.
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();
  serial_adder_ctrl #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Presents one request so that it is sampled on the next rising edge (edge 0);
  // returns 1ns after that edge with operands scrambled.
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.cin = ~cin; bus.sub = ~sub;
  endtask

  // Cycle number (1 = cycle after the accept edge) in which done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    int c = 0;
    lat = -1;
    while (lat < 0 && c < 20) begin
      @(negedge clk);
      c++;
      if (bus.done) lat = c;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.cout, bus.overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.cout, bus.overflow});
    end
    n_tests++;
    if (bus.sum !== 8'h00) begin
      n_fail++; $display("FAIL reset_sum: got %h want 00", bus.sum);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic_timing();
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.busy !== (c <= 9)) begin
        n_fail++; $display("FAIL basic_busy cyc%0d: got %b want %b", c, bus.busy, (c <= 9));
      end
      n_tests++;
      if (bus.done !== (c == 9)) begin
        n_fail++; $display("FAIL basic_done cyc%0d: got %b want %b", c, bus.done, (c == 9));
      end
      if (c == 9) begin
        n_tests++;
        if ({bus.sum, bus.cout, bus.overflow} !== {8'h10, 1'b0, 1'b0}) begin
          n_fail++; $display("FAIL basic_result: got %h/%b/%b want 10/0/0", bus.sum, bus.cout, bus.overflow);
        end
      end
    end
    n_tests++;
    if (bus.sum !== 8'h10) begin
      n_fail++; $display("FAIL basic_hold: got %h want 10", bus.sum);
    end
  endtask

  task automatic test_results();
    logic [7:0] va [5] = '{8'hFF, 8'h7F, 8'h80, 8'hAA, 8'h3C};
    logic [7:0] vb [5] = '{8'h01, 8'h01, 8'h80, 8'h55, 8'h42};
    logic       vc [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};
    logic [7:0] es [5] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h7F};
    logic       eco[5] = '{1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
    logic       eov[5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
    int lat;
    for (int i = 0; i < 5; i++) begin
      launch(va[i], vb[i], vc[i], 1'b0);
      wait_done(lat);
      n_tests++;
      if (lat != 9) begin
        n_fail++; $display("FAIL res%0d_latency: got %0d want 9", i, lat);
      end
      n_tests++;
      if ({bus.sum, bus.cout, bus.overflow} !== {es[i], eco[i], eov[i]}) begin
        n_fail++; $display("FAIL res%0d_value: got %h/%b/%b want %h/%b/%b",
                           i, bus.sum, bus.cout, bus.overflow, es[i], eco[i], eov[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int  ndone = 0;
    logic [7:0] s_seen = '0;
    logic c_seen = 1'b0;
    logic busy10 = 1'b1;
    int lat;
    launch(8'h10, 8'h20, 1'b1, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.done) begin ndone++; s_seen = bus.sum; c_seen = bus.cout; end
      if (c == 10) busy10 = bus.busy;
      bus.start = (c == 3 || c == 9);
      bus.a     = (c == 3 || c == 9) ? 8'hAA : 8'h00;
    end
    bus.start = 1'b0;
    n_tests++;
    if (ndone != 1) begin
      n_fail++; $display("FAIL busy_start_ndone: got %0d want 1", ndone);
    end
    n_tests++;
    if ({s_seen, c_seen} !== {8'h31, 1'b0}) begin
      n_fail++; $display("FAIL busy_start_sum: got %h/%b want 31/0", s_seen, c_seen);
    end
    n_tests++;
    if (busy10 !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_ignored_in_done: busy got %b want 0", busy10);
    end
    launch(8'h01, 8'h02, 1'b0, 1'b0);
    wait_done(lat);
    n_tests++;
    if (lat != 9 || bus.sum !== 8'h03) begin
      n_fail++; $display("FAIL busy_start_next: got lat %0d sum %h want 9 03", lat, bus.sum);
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    int lat;
    launch(8'h11, 8'h22, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.overflow} !== 12'h000) begin
      n_fail++; $display("FAIL midreset_outputs: got %b/%b/%h/%b/%b want all 0",
                         bus.busy, bus.done, bus.sum, bus.cout, bus.overflow);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
      if (c == 2) rst_n = 1'b1;
    end
    n_tests++;
    if (ndone != 0) begin
      n_fail++; $display("FAIL midreset_nodone: got %0d pulses want 0", ndone);
    end
    launch(8'h0F, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    n_tests++;
    if (lat != 9 || {bus.sum, bus.cout, bus.overflow} !== {8'h10, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL midreset_after: got lat %0d %h/%b/%b want 9 10/0/0",
                         lat, bus.sum, bus.cout, bus.overflow);
    end
  endtask

  task automatic test_sub();
    int lat;
    logic [9:0] exp1, exp2;
`ifdef SERIAL_SUB_EN
    exp1 = {8'hFE, 1'b0, 1'b0};
    exp2 = {8'h7F, 1'b1, 1'b1};
`else
    exp1 = {8'h0C, 1'b0, 1'b0};
    exp2 = {8'h81, 1'b0, 1'b0};
`endif
    launch(8'h05, 8'h07, 1'b0, 1'b1);
    wait_done(lat);
    n_tests++;
    if (lat != 9 || {bus.sum, bus.cout, bus.overflow} !== exp1) begin
      n_fail++; $display("FAIL sub_5_7: got lat %0d %h/%b/%b want 9 %h/%b/%b",
                         lat, bus.sum, bus.cout, bus.overflow, exp1[9:2], exp1[1], exp1[0]);
    end
    launch(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(lat);
    n_tests++;
    if (lat != 9 || {bus.sum, bus.cout, bus.overflow} !== exp2) begin
      n_fail++; $display("FAIL sub_80_1: got lat %0d %h/%b/%b want 9 %h/%b/%b",
                         lat, bus.sum, bus.cout, bus.overflow, exp2[9:2], exp2[1], exp2[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic_timing();
    test_results();
    test_start_while_busy();
    test_reset_mid();
    test_sub();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
